// File: rtl/spike_histogram.sv
// spike_histogram: per-window histogram of one-hot spike patterns with a
// ping-pong drain port. One bank accumulates while the other drains one bin
// per beat; a window completing while the drain is busy is discarded.
//
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   spike_pattern     one-hot spike vector, qualified by spike_valid
//   spike_valid       pattern present this cycle
//   out_data          bin count of the bank being drained
//   out_index         bin number of out_data
//   out_last          final bin of the drained window
//   out_valid         drain beat available
//   out_ready         consumer accepts beat on out_valid && out_ready
//   overrun           sticky: a completed window was discarded
//   bad_pattern       sticky: spike_valid seen with a non-one-hot pattern
//   fill_level        samples accepted into the current window
//   peak_index        (SPIKE_HIST_PEAK_EN only) largest bin of drained window
//
// Optional feature macro: SPIKE_HIST_PEAK_EN adds peak_index tracking.
module spike_histogram #(
  parameter int unsigned NUM_INTERVALS = 16,
  parameter int unsigned COUNT_WIDTH   = 16,
  parameter int unsigned WINDOW_LEN    = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_INTERVALS-1:0]             spike_pattern,
  input  logic                                 spike_valid,
  output logic [COUNT_WIDTH-1:0]               out_data,
  output logic [$clog2(NUM_INTERVALS)-1:0]     out_index,
  output logic                                 out_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 overrun,
  output logic                                 bad_pattern,
  output logic [$clog2(WINDOW_LEN+1)-1:0]      fill_level
`ifdef SPIKE_HIST_PEAK_EN
  ,
  output logic [$clog2(NUM_INTERVALS)-1:0]     peak_index
`endif
);

  localparam int unsigned IW = $clog2(NUM_INTERVALS);
  localparam int unsigned FW = $clog2(WINDOW_LEN + 1);

  typedef enum logic {S_IDLE, S_DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] bins_q [2][NUM_INTERVALS];
  logic [COUNT_WIDTH-1:0] bins_d [2][NUM_INTERVALS];
  logic                   sel_q, sel_d;       // bank currently accumulating
  logic [IW-1:0]          idx_q, idx_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic                   overrun_q, overrun_d;
  logic                   bad_q, bad_d;
  logic [COUNT_WIDTH-1:0] out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   out_valid_q, out_valid_d;

  logic                   onehot, accept, complete, hs, last_hs, drain_free;
  logic [IW-1:0]          bin;
  logic [COUNT_WIDTH-1:0] cur_val, new_val;
  logic                   drn_sel, drn_sel_d;

`ifdef SPIKE_HIST_PEAK_EN
  logic [IW-1:0]          pk_acc_q, pk_acc_d;  // running peak of ACC bank
  logic [IW-1:0]          peak_q, peak_d;      // latched peak of DRN bank
  logic [IW-1:0]          pk_cand;
  logic [COUNT_WIDTH-1:0] pk_val;
`endif

  // Sample qualification and bin decode
  always_comb begin
    onehot = (spike_pattern != '0) &&
             ((spike_pattern & (spike_pattern - NUM_INTERVALS'(1))) == '0);
    bin = '0;
    for (int unsigned i = 0; i < NUM_INTERVALS; i++) begin
      if (spike_pattern[i]) bin = IW'(i);
    end
    accept     = spike_valid && onehot;
    complete   = accept && (fill_q == FW'(WINDOW_LEN - 1));
    hs         = (state_q == S_DRAIN) && out_ready;
    last_hs    = hs && (idx_q == IW'(NUM_INTERVALS - 1));
    drain_free = (state_q == S_IDLE) || last_hs;
    drn_sel    = ~sel_q;
    cur_val    = bins_q[sel_q][bin];
    new_val    = (cur_val == '1) ? cur_val : cur_val + COUNT_WIDTH'(1);
  end

  // Next-state: accumulation, drain FSM, bank swap / overrun
  always_comb begin
    state_d   = state_q;
    bins_d    = bins_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    fill_d    = fill_q;
    overrun_d = overrun_q;
    bad_d     = bad_q;

    if (spike_valid && !onehot) bad_d = 1'b1;

    if (hs) begin
      bins_d[drn_sel][idx_q] = '0;
      idx_d = idx_q + IW'(1);
      if (last_hs) state_d = S_IDLE;
    end

    if (accept) begin
      bins_d[sel_q][bin] = new_val;
      fill_d = complete ? '0 : fill_q + FW'(1);
    end

    if (complete) begin
      if (drain_free) begin
        sel_d   = ~sel_q;
        state_d = S_DRAIN;
        idx_d   = '0;
      end else begin
        // Discard the finished window; restart accumulation in place.
        overrun_d = 1'b1;
        for (int unsigned i = 0; i < NUM_INTERVALS; i++) bins_d[sel_q][i] = '0;
      end
    end

    // Output registers look ahead so the beat is visible right after the edge.
    drn_sel_d   = ~sel_d;
    out_valid_d = (state_d == S_DRAIN);
    out_data_d  = (state_d == S_DRAIN) ? bins_d[drn_sel_d][idx_d] : '0;
    out_last_d  = (state_d == S_DRAIN) && (idx_d == IW'(NUM_INTERVALS - 1));
  end

`ifdef SPIKE_HIST_PEAK_EN
  // Incremental peak: counts only grow, so only the touched bin can overtake.
  always_comb begin
    pk_acc_d = pk_acc_q;
    peak_d   = peak_q;
    pk_val   = bins_q[sel_q][pk_acc_q];
    pk_cand  = pk_acc_q;
    if (accept && (bin != pk_acc_q) &&
        ((new_val > pk_val) || ((new_val == pk_val) && (bin < pk_acc_q)))) begin
      pk_cand = bin;
    end
    if (accept) pk_acc_d = pk_cand;
    if (complete) begin
      if (drain_free) peak_d = pk_cand;
      pk_acc_d = '0;
    end
  end
`endif

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned i = 0; i < NUM_INTERVALS; i++) bins_q[b][i] <= '0;
      end
      sel_q       <= 1'b0;
      idx_q       <= '0;
      fill_q      <= '0;
      overrun_q   <= 1'b0;
      bad_q       <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bins_q      <= bins_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      fill_q      <= fill_d;
      overrun_q   <= overrun_d;
      bad_q       <= bad_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef SPIKE_HIST_PEAK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pk_acc_q <= '0;
      peak_q   <= '0;
    end else begin
      pk_acc_q <= pk_acc_d;
      peak_q   <= peak_d;
    end
  end

  assign peak_index = peak_q;
`endif

  assign out_data    = out_data_q;
  assign out_index   = idx_q;
  assign out_last    = out_last_q;
  assign out_valid   = out_valid_q;
  assign overrun     = overrun_q;
  assign bad_pattern = bad_q;
  assign fill_level  = fill_q;

endmodule
